// File: rtl/calorie_line_parser.sv
// ---------------------------------------------------------------------------
// calorie_line_parser
//
// Streams an ASCII file one byte at a time and turns it into one record per
// line. A record is either a decimal line value, or a blank-line group
// delimiter. The last record of a file always carries out_group_end=1 and
// out_last=1.
//
// Handshakes: a byte moves when in_valid && in_ready are high on a rising
// edge. A record moves when out_valid && out_ready are high on a rising edge.
// While out_valid is high and out_ready is low, every out_* signal holds.
// in_ready is low whenever a record is pending, so a record never has to
// compete with the next byte.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   in_valid/in_ready/in_data/in_last : byte stream in
//   out_valid/out_ready/out_value/out_group_end/out_last : record stream out
//   dbg_state       : current FSM state (0=START, 1=NUM, 2=DONE)
//   err             : sticky error flag (only with CALORIE_PARSER_ERR_EN)
//
// Build option: define CALORIE_PARSER_ERR_EN to add the err port. err flags
// unexpected bytes and accumulator overflow. Without the macro those bytes are
// ignored and overflow wraps silently.
// ---------------------------------------------------------------------------
module calorie_line_parser #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_value,
  output logic             out_group_end,
  output logic             out_last,
  output logic [1:0]       dbg_state
`ifdef CALORIE_PARSER_ERR_EN
  ,
  output logic             err
`endif
);

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_NUM   = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_value_q, out_value_d;
  logic             out_ge_q, out_ge_d;
  logic             out_last_q, out_last_d;

  logic             accept;
  logic             is_digit;
  logic             is_lf;
  logic [WIDTH-1:0] acc_mac;

  assign accept   = in_valid && in_ready;
  assign is_digit = (in_data >= 8'h30) && (in_data <= 8'h39);
  assign is_lf    = (in_data == 8'h0A);

`ifdef CALORIE_PARSER_ERR_EN
  // Compute the product 4 bits wider so that overflow can be seen.
  // 10 * 2^WIDTH < 2^(WIDTH+4).
  logic [WIDTH+3:0] acc_wide;
  logic             is_cr;
  logic             err_q, err_d;

  assign acc_wide = {4'b0000, acc_q} * (WIDTH+4)'(10) + (WIDTH+4)'(in_data[3:0]);
  assign acc_mac  = acc_wide[WIDTH-1:0];
  assign is_cr    = (in_data == 8'h0D);

  always_comb begin
    err_d = err_q;
    if (accept) begin
      if (!is_digit && !is_lf && !is_cr) err_d = 1'b1;
      if (is_digit && (|acc_wide[WIDTH+3:WIDTH])) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`else
  // The low nibble of an ASCII digit is its value. The result wraps modulo 2^WIDTH.
  assign acc_mac = acc_q * WIDTH'(10) + WIDTH'(in_data[3:0]);
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_START;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_value_q <= '0;
      out_ge_q    <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_value_q <= out_value_d;
      out_ge_q    <= out_ge_d;
      out_last_q  <= out_last_d;
    end
  end

  // Next-state logic. An accepted byte can only arrive while no record is
  // pending, so registering a new record never overwrites one in flight.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_value_d = out_value_q;
    out_ge_d    = out_ge_q;
    out_last_d  = out_last_q;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (accept) begin
      if (is_digit) begin
        acc_d   = acc_mac;
        state_d = ST_NUM;
        if (in_last) begin
          out_valid_d = 1'b1;
          out_value_d = acc_mac;
          out_ge_d    = 1'b1;
          out_last_d  = 1'b1;
        end
      end else if (is_lf) begin
        // NUM: this is a value line. START: this is a blank-line delimiter.
        // If in_last is also set, it is folded into this same record.
        out_valid_d = 1'b1;
        out_value_d = (state_q == ST_NUM) ? acc_q : '0;
        out_ge_d    = (state_q != ST_NUM) || in_last;
        out_last_d  = in_last;
        acc_d       = '0;
        state_d     = ST_START;
      end else if (in_last) begin
        // A non-digit byte ends the file. acc_q is already 0 in START.
        out_valid_d = 1'b1;
        out_value_d = acc_q;
        out_ge_d    = 1'b1;
        out_last_d  = 1'b1;
      end
      if (in_last) state_d = ST_DONE;
    end
  end

  // Output logic
  always_comb begin
    in_ready      = !rst && !out_valid_q && (state_q != ST_DONE);
    out_valid     = out_valid_q;
    out_value     = out_value_q;
    out_group_end = out_ge_q;
    out_last      = out_last_q;
    dbg_state     = state_q;
  end

endmodule
